// File: rtl/io_ports.sv
// GPIO block: synchronised and debounced inputs with edge capture, an output register,
// a reload timer and a level interrupt, all behind a one-cycle req/ack register port.
module io_ports #(
    parameter int unsigned       N_IN          = 7,
    parameter int unsigned       N_OUT         = 3,
    parameter int unsigned       DEBOUNCE_BITS = 4,
    parameter int unsigned       TIMER_WIDTH   = 24,
    parameter logic [N_OUT-1:0]  OUT_RESET     = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [3:0]           be,
    input  logic [2:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 ack,
    input  logic [N_IN-1:0]      in_pins,
    output logic [N_OUT-1:0]     out_q,
    output logic                 irq
);

    localparam logic [2:0] A_OUT    = 3'd0;
    localparam logic [2:0] A_IN     = 3'd1;
    localparam logic [2:0] A_EDGE   = 3'd2;
    localparam logic [2:0] A_IE     = 3'd3;
    localparam logic [2:0] A_POL    = 3'd4;
    localparam logic [2:0] A_RELOAD = 3'd5;
    localparam logic [2:0] A_CTRL   = 3'd6;
    localparam logic [2:0] A_COUNT  = 3'd7;

    localparam int unsigned IE_W = N_IN + 1;
    localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = '1;
    localparam logic [DEBOUNCE_BITS-1:0] DB_ONE = DEBOUNCE_BITS'(1);
    localparam logic [TIMER_WIDTH-1:0]   TM_ONE = TIMER_WIDTH'(1);

    logic [N_IN-1:0]                     sync1_q, sync2_q;
    logic [N_IN-1:0]                     db_q, db_d;
    logic [N_IN-1:0][DEBOUNCE_BITS-1:0]  db_cnt_q, db_cnt_d;
    logic [N_IN-1:0]                     edge_q, edge_d, edge_set;
    logic [N_IN-1:0]                     pol_q, pol_d;
    logic [IE_W-1:0]                     ie_q, ie_d;
    logic [N_OUT-1:0]                    out_d;
    logic [TIMER_WIDTH-1:0]              reload_q, reload_d;
    logic [TIMER_WIDTH-1:0]              count_q, count_d;
    logic                                run_q, run_d;
    logic                                flag_q, flag_d, flag_set, flag_clr;
    logic                                ack_d, irq_d;
    logic [31:0]                         rdata_d, rd_val, wmask;
    logic                                wr_en;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] data_v,
                                          input logic [31:0] mask_v);
        return (old_v & ~mask_v) | (data_v & mask_v);
    endfunction

    assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign wr_en = req & we;

    // The debounced state only flips after DB_MAX+1 consecutive disagreeing samples.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
                end
            end
        end
        edge_set = (pol_q & ~db_q & db_d) | (~pol_q & db_q & ~db_d);
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            A_OUT:    rd_val = 32'(out_q);
            A_IN:     rd_val = 32'(db_q);
            A_EDGE:   rd_val = 32'(edge_q);
            A_IE:     rd_val = 32'(ie_q);
            A_POL:    rd_val = 32'(pol_q);
            A_RELOAD: rd_val = 32'(reload_q);
            A_CTRL:   rd_val = {30'd0, flag_q, run_q};
            A_COUNT:  rd_val = 32'(count_q);
            default:  rd_val = '0;
        endcase
    end

    always_comb begin
        out_d    = out_q;
        ie_d     = ie_q;
        pol_d    = pol_q;
        reload_d = reload_q;
        run_d    = run_q;
        flag_clr = 1'b0;
        edge_d   = edge_q | edge_set;
        if (wr_en) begin
            case (addr)
                A_OUT:    out_d    = N_OUT'(merge(32'(out_q), wdata, wmask));
                A_EDGE:   edge_d   = (edge_q & ~N_IN'(wdata & wmask)) | edge_set;
                A_IE:     ie_d     = IE_W'(merge(32'(ie_q), wdata, wmask));
                A_POL:    pol_d    = N_IN'(merge(32'(pol_q), wdata, wmask));
                A_RELOAD: reload_d = TIMER_WIDTH'(merge(32'(reload_q), wdata, wmask));
                A_CTRL: begin
                    if (be[0]) begin
                        run_d    = wdata[0];
                        flag_clr = wdata[1];
                    end
                end
                default: ;
            endcase
        end

        // Starting the timer loads COUNT; a running timer reloads only on reaching 0.
        flag_set = run_q && (count_q == '0);
        if (!run_q && run_d) begin
            count_d = reload_q;
        end else if (run_q) begin
            count_d = flag_set ? reload_q : count_q - TM_ONE;
        end else begin
            count_d = count_q;
        end
        flag_d = (flag_q & ~flag_clr) | flag_set;

        irq_d   = (|(edge_q & ie_q[N_IN-1:0])) | (flag_q & ie_q[N_IN]);
        ack_d   = req;
        rdata_d = req ? rd_val : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= OUT_RESET;
            sync1_q  <= '0;
            sync2_q  <= '0;
            db_q     <= '0;
            db_cnt_q <= '0;
            edge_q   <= '0;
            ie_q     <= '0;
            pol_q    <= '0;
            reload_q <= '0;
            count_q  <= '0;
            run_q    <= 1'b0;
            flag_q   <= 1'b0;
            ack      <= 1'b0;
            rdata    <= '0;
            irq      <= 1'b0;
        end else begin
            out_q    <= out_d;
            sync1_q  <= in_pins;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            edge_q   <= edge_d;
            ie_q     <= ie_d;
            pol_q    <= pol_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            run_q    <= run_d;
            flag_q   <= flag_d;
            ack      <= ack_d;
            rdata    <= rdata_d;
            irq      <= irq_d;
        end
    end

endmodule

// File: tb/tb_io_ports.sv
// Directed bench for io_ports: register port, debounce/edge capture, timer and reset abort.
module tb_io_ports;

    logic        clk, reset, req, we, ack, irq;
    logic [3:0]  be;
    logic [2:0]  addr;
    logic [31:0] wdata, rdata;
    logic [6:0]  in_pins;
    logic [2:0]  out_q;

    logic        got_ack;
    logic [31:0] got_rdata;
    int          total = 0;
    int          bad = 0;

    io_ports dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .be(be), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ack(ack), .in_pins(in_pins),
        .out_q(out_q), .irq(irq)
    );

    always #5 clk = ~clk;

    // One access per call: drive at a negedge, sample at the following negedge.
    task automatic bus(input logic w, input logic [2:0] a, input logic [3:0] b,
                       input logic [31:0] d);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(negedge clk);
        got_ack = ack; got_rdata = rdata;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (out_q !== 3'b111) begin bad++; $display("FAIL reset_out got=%b exp=111", out_q); end
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        reset = 1'b0;
    endtask

    task automatic test_out_write;
        bus(1, 3'd0, 4'b0001, 32'h5);
        total++; if (got_ack !== 1'b1) begin bad++; $display("FAIL out_wr_ack got=%b exp=1", got_ack); end
        total++; if (out_q !== 3'b101) begin bad++; $display("FAIL out_wr_pins got=%b exp=101", out_q); end
        bus(0, 3'd0, 4'b0000, 32'h0);
        total++; if (got_ack !== 1'b1) begin bad++; $display("FAIL out_rd_ack got=%b exp=1", got_ack); end
        total++; if (got_rdata !== 32'h5) begin bad++; $display("FAIL out_rd got=%h exp=5", got_rdata); end
        @(negedge clk);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL idle_ack got=%b exp=0", ack); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL idle_rdata got=%h exp=0", rdata); end
        bus(1, 3'd0, 4'b0000, 32'h0);
        total++; if (got_ack !== 1'b1) begin bad++; $display("FAIL be0_ack got=%b exp=1", got_ack); end
        total++; if (out_q !== 3'b101) begin bad++; $display("FAIL be0_out got=%b exp=101", out_q); end
    endtask

    task automatic test_reg_bits;
        bus(1, 3'd5, 4'b1111, 32'h00AABBCC);
        bus(1, 3'd5, 4'b0010, 32'h00112233);
        bus(0, 3'd5, 4'b0000, 32'h0);
        total++; if (got_rdata !== 32'h00AA22CC) begin bad++; $display("FAIL reload_be got=%h exp=00aa22cc", got_rdata); end
        bus(1, 3'd3, 4'b1111, 32'hFFFFFFFF);
        bus(0, 3'd3, 4'b0000, 32'h0);
        total++; if (got_rdata !== 32'h000000FF) begin bad++; $display("FAIL ie_bits got=%h exp=000000ff", got_rdata); end
        bus(1, 3'd4, 4'b1111, 32'hFFFFFFFF);
        bus(0, 3'd4, 4'b0000, 32'h0);
        total++; if (got_rdata !== 32'h0000007F) begin bad++; $display("FAIL pol_bits got=%h exp=0000007f", got_rdata); end
        bus(1, 3'd1, 4'b1111, 32'hFFFFFFFF);
        bus(0, 3'd1, 4'b0000, 32'h0);
        total++; if (got_rdata !== 32'h0) begin bad++; $display("FAIL in_ro got=%h exp=0", got_rdata); end
        bus(1, 3'd7, 4'b1111, 32'hFFFFFFFF);
        bus(0, 3'd7, 4'b0000, 32'h0);
        total++; if (got_rdata !== 32'h0) begin bad++; $display("FAIL count_ro got=%h exp=0", got_rdata); end
        bus(1, 3'd3, 4'b1111, 32'h0);
        bus(1, 3'd4, 4'b1111, 32'h0);
    endtask

    task automatic test_edge;
        bus(1, 3'd4, 4'b0001, 32'h04);
        bus(1, 3'd3, 4'b0001, 32'h04);
        in_pins[2] = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_irq_early clk=%0d got=%b exp=0", k, irq); end
        end
        bus(0, 3'd1, 4'b0000, 32'h0);
        total++; if (got_rdata !== 32'h0) begin bad++; $display("FAIL in_clk18 got=%h exp=0", got_rdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clk18 got=%b exp=0", irq); end
        bus(0, 3'd1, 4'b0000, 32'h0);
        total++; if (got_rdata !== 32'h4) begin bad++; $display("FAIL in_clk19 got=%h exp=4", got_rdata); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_clk19 got=%b exp=1", irq); end
        bus(0, 3'd2, 4'b0000, 32'h0);
        total++; if (got_rdata !== 32'h4) begin bad++; $display("FAIL edge_reg got=%h exp=4", got_rdata); end
        bus(1, 3'd2, 4'b0001, 32'h4);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_w1c_same got=%b exp=1", irq); end
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c_next got=%b exp=0", irq); end
        bus(0, 3'd2, 4'b0000, 32'h0);
        total++; if (got_rdata !== 32'h0) begin bad++; $display("FAIL edge_cleared got=%h exp=0", got_rdata); end
    endtask

    task automatic test_glitch;
        int widths [2] = '{10, 15};
        bus(1, 3'd4, 4'b0001, 32'h05);
        bus(1, 3'd3, 4'b0001, 32'h05);
        foreach (widths[j]) begin
            in_pins[0] = 1'b1;
            repeat (widths[j]) @(negedge clk);
            in_pins[0] = 1'b0;
            repeat (25) @(negedge clk);
            bus(0, 3'd1, 4'b0000, 32'h0);
            total++; if (got_rdata !== 32'h4) begin bad++; $display("FAIL glitch%0d_in got=%h exp=4", widths[j], got_rdata); end
            bus(0, 3'd2, 4'b0000, 32'h0);
            total++; if (got_rdata !== 32'h0) begin bad++; $display("FAIL glitch%0d_edge got=%h exp=0", widths[j], got_rdata); end
            total++; if (irq !== 1'b0) begin bad++; $display("FAIL glitch%0d_irq got=%b exp=0", widths[j], irq); end
        end
    endtask

    task automatic test_timer;
        bus(1, 3'd5, 4'b1111, 32'h4);
        bus(1, 3'd3, 4'b0001, 32'h80);
        bus(1, 3'd6, 4'b0001, 32'h1);                               // W
        bus(0, 3'd7, 4'b0000, 32'h0);                               // W+1
        total++; if (got_rdata !== 32'h4) begin bad++; $display("FAIL tm_start got=%h exp=4", got_rdata); end
        bus(0, 3'd7, 4'b0000, 32'h0);                               // W+2
        total++; if (got_rdata !== 32'h3) begin bad++; $display("FAIL tm_dec got=%h exp=3", got_rdata); end
        bus(0, 3'd6, 4'b0000, 32'h0);                               // W+3
        total++; if (got_rdata !== 32'h1) begin bad++; $display("FAIL tm_ctrl_run got=%h exp=1", got_rdata); end
        @(negedge clk);                                             // W+4
        bus(0, 3'd6, 4'b0000, 32'h0);                               // W+5
        total++; if (got_rdata !== 32'h1) begin bad++; $display("FAIL tm_flag_pre got=%h exp=1", got_rdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL tm_irq_pre got=%b exp=0", irq); end
        bus(0, 3'd6, 4'b0000, 32'h0);                               // W+6
        total++; if (got_rdata !== 32'h3) begin bad++; $display("FAIL tm_flag_set got=%h exp=3", got_rdata); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL tm_irq got=%b exp=1", irq); end
        bus(0, 3'd7, 4'b0000, 32'h0);                               // W+7
        total++; if (got_rdata !== 32'h3) begin bad++; $display("FAIL tm_reloaded got=%h exp=3", got_rdata); end
        repeat (2) @(negedge clk);                                  // W+8, W+9
        bus(1, 3'd6, 4'b0001, 32'h3);                               // W+10: set and clear coincide
        bus(0, 3'd6, 4'b0000, 32'h0);                               // W+11
        total++; if (got_rdata !== 32'h3) begin bad++; $display("FAIL tm_set_wins got=%h exp=3", got_rdata); end
        bus(1, 3'd6, 4'b0001, 32'h3);                               // W+12
        bus(0, 3'd6, 4'b0000, 32'h0);                               // W+13
        total++; if (got_rdata !== 32'h1) begin bad++; $display("FAIL tm_w1c got=%h exp=1", got_rdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL tm_irq_clr got=%b exp=0", irq); end
        bus(1, 3'd5, 4'b1111, 32'h2);                               // W+14
        bus(0, 3'd7, 4'b0000, 32'h0);                               // W+15
        total++; if (got_rdata !== 32'h0) begin bad++; $display("FAIL tm_reload_defer got=%h exp=0", got_rdata); end
        bus(0, 3'd7, 4'b0000, 32'h0);                               // W+16
        total++; if (got_rdata !== 32'h2) begin bad++; $display("FAIL tm_new_reload got=%h exp=2", got_rdata); end
        bus(0, 3'd7, 4'b0000, 32'h0);                               // W+17
        total++; if (got_rdata !== 32'h1) begin bad++; $display("FAIL tm_dec2 got=%h exp=1", got_rdata); end
        bus(1, 3'd6, 4'b0001, 32'h0);                               // W+18: stop
        bus(0, 3'd7, 4'b0000, 32'h0);
        total++; if (got_rdata !== 32'h2) begin bad++; $display("FAIL tm_stop got=%h exp=2", got_rdata); end
        repeat (3) @(negedge clk);
        bus(0, 3'd7, 4'b0000, 32'h0);
        total++; if (got_rdata !== 32'h2) begin bad++; $display("FAIL tm_hold got=%h exp=2", got_rdata); end
    endtask

    task automatic test_back_to_back_reset;
        logic [31:0] exp_v;
        bus(0, 3'd1, 4'b0000, 32'h0);
        total++; if (got_ack !== 1'b1 || got_rdata !== 32'h4) begin bad++; $display("FAIL b2b_in ack=%b got=%h exp=4", got_ack, got_rdata); end
        bus(0, 3'd7, 4'b0000, 32'h0);
        total++; if (got_ack !== 1'b1 || got_rdata !== 32'h2) begin bad++; $display("FAIL b2b_count ack=%b got=%h exp=2", got_ack, got_rdata); end
        bus(0, 3'd6, 4'b0000, 32'h0);
        total++; if (got_ack !== 1'b1 || got_rdata !== 32'h2) begin bad++; $display("FAIL b2b_ctrl ack=%b got=%h exp=2", got_ack, got_rdata); end
        reset = 1'b1;
        bus(1, 3'd0, 4'b1111, 32'h0);                               // R: aborted access
        reset = 1'b0;
        total++; if (got_ack !== 1'b0) begin bad++; $display("FAIL abort_ack got=%b exp=0", got_ack); end
        total++; if (out_q !== 3'b111) begin bad++; $display("FAIL abort_out got=%b exp=111", out_q); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL abort_irq got=%b exp=0", irq); end
        for (int a = 0; a < 8; a++) begin                           // R+1 .. R+8
            bus(0, 3'(a), 4'b0000, 32'h0);
            exp_v = (a == 0) ? 32'h7 : 32'h0;
            total++; if (got_rdata !== exp_v) begin bad++; $display("FAIL post_reset_reg%0d got=%h exp=%h", a, got_rdata, exp_v); end
        end
        bus(1, 3'd4, 4'b0001, 32'h04);                              // R+9
        bus(1, 3'd3, 4'b0001, 32'h04);                              // R+10
        repeat (7) @(negedge clk);                                  // R+11 .. R+17
        bus(0, 3'd1, 4'b0000, 32'h0);                               // R+18
        total++; if (got_rdata !== 32'h0) begin bad++; $display("FAIL rst_in_clk18 got=%h exp=0", got_rdata); end
        bus(0, 3'd2, 4'b0000, 32'h0);                               // R+19
        total++; if (got_rdata !== 32'h4) begin bad++; $display("FAIL rst_edge got=%h exp=4", got_rdata); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL rst_irq got=%b exp=1", irq); end
        bus(1, 3'd2, 4'b0001, 32'h4);
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq_clr got=%b exp=0", irq); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; reset = 1'b1; req = 1'b0; we = 1'b0;
        be = 4'b0; addr = 3'd0; wdata = 32'h0; in_pins = 7'h0;
        got_ack = 1'b0; got_rdata = 32'h0;
        test_reset;
        test_out_write;
        test_reg_bits;
        test_edge;
        test_glitch;
        test_timer;
        test_back_to_back_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
